// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: decimates ADC samples into one frame, drives the FFT core and forwards bins with L1 magnitude
module fft_frame_sequencer #(
  parameter int ADC_W = 8,
  parameter int LOG2_DECIM = 5,
  parameter int FFT_W = 8,
  parameter int LOG2_N = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              continuous,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  sample,
  output logic              fft_start,
  input  logic              fft_ipd,
  output logic [FFT_W-1:0]  fft_xn_re,
  output logic [FFT_W-1:0]  fft_xn_im,
  input  logic              fft_opd,
  input  logic              fft_eoud,
  input  logic [LOG2_N-1:0] fft_idx,
  input  logic [FFT_W-1:0]  fft_xk_re,
  input  logic [FFT_W-1:0]  fft_xk_im,
  output logic              bin_valid,
  output logic [LOG2_N-1:0] bin_idx,
  output logic [FFT_W-1:0]  bin_re,
  output logic [FFT_W-1:0]  bin_im,
  output logic [FFT_W:0]    bin_mag,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);
  localparam int SUM_W = ADC_W + LOG2_DECIM;
  localparam int N = 1 << LOG2_N;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FILL, START, LOAD, UNLOAD} state_t;
  state_t state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic dec_valid_q, dec_valid_d;
  logic [FFT_W-1:0] dec_data_q, dec_data_d;
  logic [FFT_W-1:0] mem_q [N];
  logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic fft_start_q, fft_start_d, busy_q, busy_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic bin_valid_q, bin_valid_d, frame_done_q, frame_done_d;
  logic [LOG2_N-1:0] bin_idx_q, bin_idx_d;
  logic [FFT_W-1:0] bin_re_q, bin_re_d, bin_im_q, bin_im_d;
  logic [FFT_W:0] bin_mag_q, bin_mag_d, re_x, im_x, abs_re, abs_im;
  logic arm_ok, wd_exp;
  always_comb begin
    sum = acc_q + SUM_W'(sample);
    acc_d = sample_valid ? (&cnt_q ? '0 : sum) : acc_q;
    cnt_d = cnt_q + LOG2_DECIM'(sample_valid);
    dec_valid_d = sample_valid && &cnt_q;
    dec_data_d = dec_valid_d ? {~sum[SUM_W-1], sum[SUM_W-2 -: FFT_W-1]} : dec_data_q;
  end
  always_comb begin
    re_x = {fft_xk_re[FFT_W-1], fft_xk_re};
    im_x = {fft_xk_im[FFT_W-1], fft_xk_im};
    abs_re = re_x[FFT_W] ? -re_x : re_x;
    abs_im = im_x[FFT_W] ? -im_x : im_x;
  end
  always_comb begin
    arm_ok = arm && state_q == IDLE;
    wd_exp = wd_q == WD_W'(TIMEOUT - 1);
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wd_d = wd_q;
    overrun_d = (overrun_q && !arm_ok) || (dec_valid_q && state_q != FILL);
    timeout_d = timeout_q && !arm_ok;
    bin_valid_d = 1'b0;
    frame_done_d = 1'b0;
    bin_idx_d = bin_idx_q;
    bin_re_d = bin_re_q;
    bin_im_d = bin_im_q;
    bin_mag_d = bin_mag_q;
    case (state_q)
      IDLE: if (arm || continuous) begin
        state_d = FILL;
        wr_ptr_d = '0;
      end
      FILL: if (dec_valid_q) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d = &wr_ptr_q ? START : FILL;
      end
      START: begin
        state_d = LOAD;
        rd_ptr_d = '0;
        wd_d = '0;
      end
      LOAD: if (fft_ipd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        wd_d = '0;
        state_d = &rd_ptr_q ? UNLOAD : LOAD;
      end else if (wd_exp) begin
        timeout_d = 1'b1;
        state_d = IDLE;
      end else
        wd_d = wd_q + 1'b1;
      UNLOAD: if (fft_opd) begin
        wd_d = '0;
        bin_valid_d = 1'b1;
        bin_idx_d = fft_idx;
        bin_re_d = fft_xk_re;
        bin_im_d = fft_xk_im;
        bin_mag_d = abs_re + abs_im;
        frame_done_d = fft_eoud;
        if (fft_eoud) begin
          state_d = continuous ? FILL : IDLE;
          wr_ptr_d = '0;
        end
      end else if (wd_exp) begin
        timeout_d = 1'b1;
        state_d = IDLE;
      end else
        wd_d = wd_q + 1'b1;
      default: state_d = IDLE;
    endcase
    fft_start_d = state_d == START;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (state_q == FILL && dec_valid_q) mem_q[wr_ptr_q] <= dec_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      dec_valid_q <= 1'b0;
      dec_data_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wd_q <= '0;
      fft_start_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      bin_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      bin_idx_q <= '0;
      bin_re_q <= '0;
      bin_im_q <= '0;
      bin_mag_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q <= dec_data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wd_q <= wd_d;
      fft_start_q <= fft_start_d;
      busy_q <= busy_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      bin_valid_q <= bin_valid_d;
      frame_done_q <= frame_done_d;
      bin_idx_q <= bin_idx_d;
      bin_re_q <= bin_re_d;
      bin_im_q <= bin_im_d;
      bin_mag_q <= bin_mag_d;
    end
  end
  assign fft_start = fft_start_q;
  assign fft_xn_re = state_q == LOAD ? mem_q[rd_ptr_q] : '0;
  assign fft_xn_im = '0;
  assign bin_valid = bin_valid_q;
  assign bin_idx = bin_idx_q;
  assign bin_re = bin_re_q;
  assign bin_im = bin_im_q;
  assign bin_mag = bin_mag_q;
  assign frame_done = frame_done_q;
  assign busy = busy_q;
  assign overrun = overrun_q;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: drives ADC samples and acts as the FFT core, checking frames and bins against a model
module tb_fft_frame_sequencer;
  logic clk = 1'b0;
  logic rst, arm, continuous, sample_valid, fft_ipd, fft_opd, fft_eoud;
  logic [7:0] sample, fft_xk_re, fft_xk_im, fft_xn_re, fft_xn_im, bin_re, bin_im;
  logic [5:0] fft_idx, bin_idx;
  logic [8:0] bin_mag;
  logic fft_start, bin_valid, frame_done, busy, overrun, timeout_err;
  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    logic [8:0] mag;
  } bin_vec_t;
  bin_vec_t tbl[8];
  logic [7:0] exp_pts[$];
  int n_cmp = 0, n_bad = 0, fd_cnt = 0, fd_exp = 0, msum = 0, mcnt = 0;
  fft_frame_sequencer dut (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous),
    .sample_valid(sample_valid), .sample(sample),
    .fft_start(fft_start), .fft_ipd(fft_ipd), .fft_xn_re(fft_xn_re), .fft_xn_im(fft_xn_im),
    .fft_opd(fft_opd), .fft_eoud(fft_eoud), .fft_idx(fft_idx),
    .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im),
    .bin_mag(bin_mag), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [8:0] mag_of(input logic [7:0] v);
    int a;
    a = $signed(v);
    return 9'(a < 0 ? -a : a);
  endfunction
  task automatic feed(input int mode, input int npts, input bit keep);
    logic [7:0] s;
    for (int p = 0; p < npts; p++)
      for (int k = 0; k < 32; k++) begin
        s = mode == 0 ? 8'h80 : mode == 1 ? 8'(p * 4 + k) : mode == 2 ? 8'hff : 8'($urandom);
        if ($urandom_range(3) == 0) begin
          sample_valid = 1'b0;
          step();
        end
        sample_valid = 1'b1;
        sample = s;
        msum += s;
        mcnt++;
        if (mcnt == 32) begin
          if (keep) exp_pts.push_back(8'((msum >> 5) ^ 128));
          msum = 0;
          mcnt = 0;
        end
        step();
        sample_valid = 1'b0;
      end
  endtask
  task automatic wait_start();
    int t = 0;
    while (fft_start !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("fft_start", fft_start, 1);
    step();
    chk("fft_start_width", fft_start, 0);
  endtask
  task automatic load(input bit ovr_during);
    if (ovr_during) begin
      feed(3, 1, 0);
      step();
      chk("overrun_set", overrun, 1);
    end
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(4) == 0) begin
        fft_ipd = 1'b0;
        step();
      end
      fft_ipd = 1'b1;
      chk($sformatf("xn_re[%0d]", i), fft_xn_re, i < exp_pts.size() ? exp_pts[i] : 8'h00);
      step();
    end
    fft_ipd = 1'b0;
    exp_pts.delete();
    chk("busy_unload", busy, 1);
  endtask
  task automatic unload(input bit use_tbl, input int stop_at);
    logic [7:0] re, im;
    logic [8:0] mag;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(4) == 0) begin
        fft_opd = 1'b0;
        step();
        chk("bin_idle", bin_valid, 0);
      end
      re = use_tbl && i < 8 ? tbl[i].re : 8'($urandom);
      im = use_tbl && i < 8 ? tbl[i].im : 8'($urandom);
      mag = use_tbl && i < 8 ? tbl[i].mag : mag_of(re) + mag_of(im);
      fft_opd = 1'b1;
      fft_idx = 6'(i);
      fft_xk_re = re;
      fft_xk_im = im;
      fft_eoud = i == 63;
      step();
      fft_opd = 1'b0;
      fft_eoud = 1'b0;
      chk($sformatf("bin_valid[%0d]", i), bin_valid, 1);
      chk($sformatf("bin[%0d]", i), {bin_idx, bin_re, bin_im, bin_mag}, {6'(i), re, im, mag});
      chk($sformatf("frame_done[%0d]", i), frame_done, i == 63);
      if (i == stop_at) return;
    end
    step();
    chk("bin_after", {bin_valid, frame_done}, 2'b00);
  endtask
  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask
  task automatic full_frame(input int mode, input bit use_tbl);
    arm_pulse();
    chk("busy_armed", busy, 1);
    feed(mode, 64, 1);
    wait_start();
    load(0);
    unload(use_tbl, -1);
    fd_exp++;
    chk("busy_done", busy, 0);
    chk("frame_done_count", fd_cnt, fd_exp);
  endtask
  initial begin
    tbl[0] = '{8'h00, 8'h00, 9'd0};
    tbl[1] = '{8'h7f, 8'h7f, 9'd254};
    tbl[2] = '{8'hff, 8'h01, 9'd2};
    tbl[3] = '{8'h7f, 8'h80, 9'd255};
    tbl[4] = '{8'h80, 8'h00, 9'd128};
    tbl[5] = '{8'h80, 8'h80, 9'd256};
    tbl[6] = '{8'h05, 8'hfd, 9'd8};
    tbl[7] = '{8'h9c, 8'h32, 9'd150};
    {rst, arm, continuous, sample_valid, fft_ipd, fft_opd, fft_eoud} = 7'b1000000;
    {sample, fft_idx, fft_xk_re, fft_xk_im} = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_outputs", {fft_start, fft_xn_re, fft_xn_im, bin_valid, bin_idx, bin_re, bin_im,
        bin_mag, frame_done, busy, overrun, timeout_err}, 64'd0);
    full_frame(0, 1);
    full_frame(1, 0);
    full_frame(2, 0);
    continuous = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      feed(3, 64, 1);
      wait_start();
      load(f == 0);
      if (f == 2) continuous = 1'b0;
      unload(0, -1);
      fd_exp++;
      chk("busy_continuous", busy, f < 2);
    end
    chk("continuous_frames", fd_cnt, fd_exp);
    chk("overrun_sticky", overrun, 1);
    arm_pulse();
    chk("overrun_cleared", overrun, 0);
    feed(3, 64, 1);
    wait_start();
    load(1);
    unload(0, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    msum = 0;
    mcnt = 0;
    chk("reset_mid_unload", {fft_start, fft_xn_re, fft_xn_im, bin_valid, bin_idx, bin_re, bin_im,
        bin_mag, frame_done, busy, overrun, timeout_err}, 64'd0);
    chk("reset_no_done", fd_cnt, fd_exp);
    full_frame(3, 0);
    arm_pulse();
    feed(3, 64, 1);
    exp_pts.delete();
    wait_start();
    repeat (4089) step();
    chk("timeout_early", {busy, timeout_err}, 2'b10);
    for (int t = 0; t < 20 && busy === 1'b1; t++) step();
    chk("timeout_state", {busy, timeout_err}, 2'b01);
    chk("timeout_no_done", fd_cnt, fd_exp);
    arm_pulse();
    chk("timeout_cleared", {busy, timeout_err}, 2'b10);
    fft_ipd = 1'b1;
    fft_opd = 1'b1;
    step();
    fft_ipd = 1'b0;
    fft_opd = 1'b0;
    chk("handshake_outside", {bin_valid, fft_xn_re}, 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences the FFT core for the Pmod ADC spectrum path. It decimates the raw ADC sample stream by box-car summing, buffers one frame of N points, and issues the FFT start pulse. It then streams the buffered frame into the core and forwards the output bins with an L1 magnitude. It sits between the ADC front-end (sample counter/strobe) and fft_inst, and owns arming, frame timing, overrun and timeout reporting.

Parameters:
ADC_W, 8, raw ADC sample width (unsigned, offset binary)
LOG2_DECIM, 5, log2 of samples summed per decimated point (32 -> 13-bit sum)
FFT_W, 8, FFT input/output data width (signed)
LOG2_N, 6, log2 of FFT frame length (N = 64)
TIMEOUT, 4096, max cycles waiting on fft_ipd / fft_opd before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
arm  in  1  1-cycle pulse: capture one frame (ignored unless IDLE)
continuous  in  1  1 = re-arm automatically after each frame
sample_valid  in  1  raw ADC sample strobe
sample  in  ADC_W  raw ADC sample
fft_start  out  1  1-cycle start pulse to FFT core
fft_ipd  in  1  FFT input phase: consumes fft_xn_re each cycle while high
fft_xn_re  out  FFT_W  frame point to FFT
fft_xn_im  out  FFT_W  constant 0
fft_opd  in  1  FFT output valid
fft_eoud  in  1  FFT last output (qualified by fft_opd)
fft_idx  in  LOG2_N  FFT output bin index
fft_xk_re  in  FFT_W  FFT output real
fft_xk_im  in  FFT_W  FFT output imag
bin_valid  out  1  registered output bin valid
bin_idx  out  LOG2_N  bin index
bin_re  out  FFT_W  bin real
bin_im  out  FFT_W  bin imag
bin_mag  out  FFT_W+1  |re|+|im|, unsigned
frame_done  out  1  1-cycle pulse, same cycle as last bin_valid
busy  out  1  high in any state but IDLE
overrun  out  1  sticky: decimated point dropped outside FILL
timeout_err  out  1  sticky: TIMEOUT expired

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, decimation counter, pointers, watchdog cleared. Reset mid-frame aborts with no frame_done.
- Decimator runs in every state. Each sample_valid adds sample into the SUM_W = ADC_W+LOG2_DECIM accumulator. On the 2^LOG2_DECIM-th sample, the final sum (including that sample) yields dec_valid for 1 cycle, and the accumulator restarts from 0 the same cycle.
- dec_data = sum[SUM_W-1 -: FFT_W] with MSB inverted (offset binary -> two's complement). Example: sum 0x1000 -> 0x00; sum 0x1FFF -> 0x7F; sum 0 -> 0x80.
- States:
  - IDLE: -> FILL on arm or continuous; wr_ptr = 0.
  - FILL: each dec_valid writes buf[wr_ptr] and increments wr_ptr. The write of point N-1 -> START.
  - START: fft_start = 1 for exactly 1 cycle; rd_ptr = 0; watchdog = 0 -> LOAD.
  - LOAD: fft_xn_re = buf[rd_ptr] combinationally. Each cycle fft_ipd = 1, rd_ptr++ and the watchdog clears. After the Nth consumed point -> UNLOAD; outside LOAD, fft_xn_re = 0.
  - UNLOAD: each fft_opd registers idx/re/im/mag to bin_* with bin_valid next cycle (1-cycle latency); any opd clears the watchdog. fft_opd & fft_eoud -> frame_done asserted with that bin; then -> FILL (wr_ptr = 0) if continuous, else IDLE.
- Watchdog: in LOAD/UNLOAD, counts cycles without ipd/opd. Reaching TIMEOUT sets timeout_err, drops to IDLE and emits no frame_done.
- Overrun: dec_valid in any state other than FILL discards the point and sets overrun. overrun and timeout_err are cleared only by rst or an accepted arm.
- bin_mag: |re| + |im|, computed at FFT_W+1 bits; |-128| = 128, so no saturation. Maximum 256 for re = im = -128.
- arm while busy: ignored. continuous dropped mid-frame: the current frame completes, then -> IDLE.
- fft_ipd outside LOAD and fft_opd outside UNLOAD: ignored, no bin_valid.

Test Plan:
- Reset, then arm. Feed 64x32 samples of constant 0x80 -> 64 writes of 0x00, 1 fft_start pulse, 64 fft_xn_re = 0x00 during ipd.
- Ramp input: sample = k within point p -> fft_xn_re order matches fill order. Feed 2048 samples of 0xFF -> each point 0x7F.
- FFT model returns re = -128, im = -128 at idx 5 -> bin_mag = 256 one cycle after fft_opd. eoud on idx 63 -> frame_done coincident with the last bin_valid.
- continuous = 1 over 3 frames -> 3 frame_done pulses. Decimated points during LOAD/UNLOAD -> overrun = 1. Next arm pulse in IDLE -> overrun cleared.
- Hold fft_ipd low after start for 4096 cycles -> timeout_err = 1, busy = 0, no frame_done.
- Assert rst in UNLOAD mid-frame -> all outputs 0 next cycle. Arm then captures a full fresh frame.
